// File: rtl/spike_pkg.sv
// -----------------------------------------------------------------------------
// spike_pkg
// Shared definitions for the spike-rate decoder: controller state encoding and
// default sizing constants. Imported by spike_rate_decoder.
// -----------------------------------------------------------------------------
package spike_pkg;

  // Controller states: IDLE holds the window logic cleared, COUNT accumulates.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  localparam int DEF_WINDOW_LOG2 = 8;
  localparam int DEF_COUNT_W     = 8;
  localparam int DEF_ISI_W       = 8;

endpackage

// File: rtl/spike_rate_decoder_rate_out_buf.sv
// -----------------------------------------------------------------------------
// rate_out_buf
// Single-entry valid/ready holding register for completed window results.
// A new result is accepted when the buffer is empty or is being taken in the
// same cycle; otherwise it is dropped and the sticky overrun flag is raised.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load_i          a new result is presented this cycle
//   data_i, sat_i   result count and saturation flag
//   ready_i         consumer accepts the held result
//   overrun_clr_i   clears the sticky overrun flag (a drop wins over clear)
//   data_o, sat_o   held result (kept after it is taken)
//   valid_o         held result has not been taken yet
//   overrun_o       sticky: at least one result was dropped
// -----------------------------------------------------------------------------
module rate_out_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              sat_i,
  input  logic              ready_i,
  input  logic              overrun_clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              sat_o,
  output logic              valid_o,
  output logic              overrun_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              sat_q, sat_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              take_s;
  logic              accept_s;
  logic              drop_s;

  assign take_s   = valid_q & ready_i;
  assign accept_s = load_i & (~valid_q | take_s);
  assign drop_s   = load_i & valid_q & ~ready_i;

  // Next-state for the holding register, valid flag and sticky overrun.
  always_comb begin
    data_d    = data_q;
    sat_d     = sat_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (accept_s) begin
      data_d  = data_i;
      sat_d   = sat_i;
      valid_d = 1'b1;
    end else if (take_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    // Setting has priority so a drop coinciding with a clear is never lost.
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= {DATA_W{1'b0}};
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign sat_o     = sat_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
// Decodes a 1-bit spike stream into a firing rate: spikes are counted over a
// window of 2**WINDOW_LOG2 cycles and each window's count is offered through a
// single-entry valid/ready buffer (rate_out_buf).
//
// Optional feature: define SPIKE_ISI_EN to add the inter-spike-interval
// measurement and the isi_out port (and the ISI_W parameter).
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   en            enable; low returns to idle and discards the partial window
//   spike         one spike per high cycle
//   rate_out      spike count of the last completed window (saturating)
//   rate_sat      count saturated during that window
//   rate_valid    rate_out/rate_sat hold an untaken result
//   rate_ready    consumer accepts the result
//   overrun       sticky: a window result was dropped
//   overrun_clr   clears overrun
//   isi_out       last inter-spike interval in cycles (SPIKE_ISI_EN only)
// -----------------------------------------------------------------------------
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2,
  parameter int COUNT_W     = DEF_COUNT_W
`ifdef SPIKE_ISI_EN
  ,
  parameter int ISI_W       = DEF_ISI_W
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               spike,
  output logic [COUNT_W-1:0] rate_out,
  output logic               rate_sat,
  output logic               rate_valid,
  input  logic               rate_ready,
  output logic               overrun,
  input  logic               overrun_clr
`ifdef SPIKE_ISI_EN
  ,
  output logic [ISI_W-1:0]   isi_out
`endif
);

  localparam logic [WINDOW_LOG2-1:0] WIN_MAX  = {WINDOW_LOG2{1'b1}};
  localparam logic [WINDOW_LOG2-1:0] WIN_ZERO = {WINDOW_LOG2{1'b0}};
  localparam logic [COUNT_W-1:0]     CNT_MAX  = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0]     CNT_ZERO = {COUNT_W{1'b0}};

  state_e                 state_q, state_d;
  logic [WINDOW_LOG2-1:0] win_q, win_d;
  logic [COUNT_W-1:0]     cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic [COUNT_W-1:0]     cnt_inc_s;
  logic                   sat_inc_s;
  logic                   win_end_s;

  // The count including this cycle's spike; a spike arriving at full scale
  // is lost and flags the window as saturated.
  assign cnt_inc_s = (spike && (cnt_q != CNT_MAX)) ? (cnt_q + COUNT_W'(1)) : cnt_q;
  assign sat_inc_s = sat_q | (spike & (cnt_q == CNT_MAX));

  // Controller next-state: window counter, spike count and saturation flag.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    win_end_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        win_d = WIN_ZERO;
        cnt_d = CNT_ZERO;
        sat_d = 1'b0;
        if (en) begin
          state_d = ST_COUNT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (!en) begin
          // Partial window is discarded; the next enable starts afresh.
          state_d = ST_IDLE;
          win_d   = WIN_ZERO;
          cnt_d   = CNT_ZERO;
          sat_d   = 1'b0;
        end else begin
          state_d = ST_COUNT;
          win_d   = win_q + WINDOW_LOG2'(1);
          if (win_q == WIN_MAX) begin
            // Result (cnt_inc_s) leaves now; the next window starts from zero.
            win_end_s = 1'b1;
            cnt_d     = CNT_ZERO;
            sat_d     = 1'b0;
          end else begin
            cnt_d = cnt_inc_s;
            sat_d = sat_inc_s;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        win_d   = WIN_ZERO;
        cnt_d   = CNT_ZERO;
        sat_d   = 1'b0;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      win_q   <= WIN_ZERO;
      cnt_q   <= CNT_ZERO;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  rate_out_buf #(
    .DATA_W(COUNT_W)
  ) u_rate_out_buf (
    .clk          (clk),
    .rst          (rst),
    .load_i       (win_end_s),
    .data_i       (cnt_inc_s),
    .sat_i        (sat_inc_s),
    .ready_i      (rate_ready),
    .overrun_clr_i(overrun_clr),
    .data_o       (rate_out),
    .sat_o        (rate_sat),
    .valid_o      (rate_valid),
    .overrun_o    (overrun)
  );

`ifdef SPIKE_ISI_EN
  localparam logic [ISI_W-1:0] ISI_MAX  = {ISI_W{1'b1}};
  localparam logic [ISI_W-1:0] ISI_ZERO = {ISI_W{1'b0}};

  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
  logic [ISI_W-1:0] isi_q, isi_d;
  logic [ISI_W-1:0] isi_inc_s;

  assign isi_inc_s = (isi_cnt_q == ISI_MAX) ? ISI_MAX : (isi_cnt_q + ISI_W'(1));

  // Interval counter: the reported interval includes the spike cycle itself.
  always_comb begin
    isi_cnt_d = isi_cnt_q;
    isi_d     = isi_q;
    if ((state_q == ST_COUNT) && en) begin
      if (spike) begin
        isi_d     = isi_inc_s;
        isi_cnt_d = ISI_ZERO;
      end else begin
        isi_cnt_d = isi_inc_s;
      end
    end else begin
      isi_cnt_d = ISI_ZERO;
    end
  end

  // Interval counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isi_cnt_q <= ISI_ZERO;
      isi_q     <= ISI_ZERO;
    end else begin
      isi_cnt_q <= isi_cnt_d;
      isi_q     <= isi_d;
    end
  end

  assign isi_out = isi_q;
`endif

endmodule
